// File: rtl/fifo_fwft_param_pkg.sv
// Shared FIFO defaults and the pointer-width helper, reused by the CRC
// top-level instantiations so every FIFO in the datapath sizes itself the same way.
package fifo_fwft_param_pkg;

   localparam int FIFO_DEF_WIDTH    = 8;
   localparam int FIFO_DEF_DEPTH    = 8;
   localparam int FIFO_DEF_AE_LEVEL = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Data is never reset; the owner masks it while the FIFO is empty.
module fifo_mem
   import fifo_fwft_param_pkg::*;
#(
   parameter int WIDTH = FIFO_DEF_WIDTH,
   parameter int DEPTH = FIFO_DEF_DEPTH,
   parameter int AW    = clog2(FIFO_DEF_DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_fwft_param.sv
// First-word-fall-through FIFO: head visible on rd_data one cycle after the push,
// pops stream one word per cycle; pushes to a full FIFO are accepted only alongside a pop.
module fifo_fwft_param
   import fifo_fwft_param_pkg::*;
#(
   parameter int  WIDTH    = FIFO_DEF_WIDTH,
   parameter int  DEPTH    = FIFO_DEF_DEPTH,
   parameter int  AF_LEVEL = DEPTH - 2,
   parameter int  AE_LEVEL = FIFO_DEF_AE_LEVEL,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [AW:0]      count,
   input  logic             flush,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             empty;
   logic             do_wr, do_rd;
   logic [WIDTH-1:0] mem_rdata;

   assign empty        = (count_q == '0);
   assign full         = (count_q == (AW+1)'(DEPTH));
   assign almost_full  = (count_q >= (AW+1)'(AF_LEVEL));
   assign almost_empty = (count_q <= (AW+1)'(AE_LEVEL));
   assign valid        = !empty;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign rd_data      = empty ? '0 : mem_rdata;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_wr = wr_en && (!full || rd_en) && !flush;
   assign do_rd = rd_en && !empty && !flush;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q && !clr_err;
      unf_d   = unf_q && !clr_err;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_wr) wptr_d = wptr_q + AW'(1);
         if (do_rd) rptr_d = rptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
         // A set event outranks clr_err in the same cycle.
         if (wr_en && full && !rd_en) ovf_d = 1'b1;
         if (rd_en && empty)          unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (do_wr),
      .waddr (wptr_q),
      .wdata (wr_data),
      .raddr (rptr_q),
      .rdata (mem_rdata)
   );

endmodule
